// File: rtl/mul_hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_hilo_ctrl_pkg
// Purpose  : Shared types and widths for the multiply sequencer and its
//            HI/LO register file.
// Contents : state_t (ST_IDLE / ST_CALC / ST_WRITE), HILO_W, PROD_W, CNT_W
// Revision : 1.0 - initial release
// ============================================================================
package mul_hilo_ctrl_pkg;

    localparam int HILO_W = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_hilo_ctrl_hilo_regfile.sv
`default_nettype none
// ============================================================================
// Module   : hilo_regfile
// Purpose  : Architectural HI/LO registers. A product capture takes priority
//            over mthi/mtlo writes. Provides the mfhi/mflo read mux, which can
//            optionally forward the live multiplier product.
// Ports    : clk, clr_n      - clock, async active-low clear
//            capture, prod   - load {HI,LO} from the 64-bit product
//            hi_we, lo_we    - gated mthi/mtlo strobes, wr_data payload
//            hi_rd, lo_rd    - read selects (hi_rd wins)
//            rd_bypass       - read from prod instead of the registers
//            hi_q, lo_q      - register contents; rd_data - read result
// Revision : 1.0 - initial release
// ============================================================================
module hilo_regfile
    import mul_hilo_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              capture,
    input  logic [PROD_W-1:0] prod,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [HILO_W-1:0] wr_data,
    input  logic              hi_rd,
    input  logic              lo_rd,
    input  logic              rd_bypass,
    output logic [HILO_W-1:0] hi_q,
    output logic [HILO_W-1:0] lo_q,
    output logic [HILO_W-1:0] rd_data
);

    logic [HILO_W-1:0] hi_src;
    logic [HILO_W-1:0] lo_src;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (capture) begin
            hi_q <= prod[PROD_W-1:HILO_W];
            lo_q <= prod[HILO_W-1:0];
        end else begin
            if (hi_we) hi_q <= wr_data;
            if (lo_we) lo_q <= wr_data;
        end
    end

    always_comb begin
        hi_src  = rd_bypass ? prod[PROD_W-1:HILO_W] : hi_q;
        lo_src  = rd_bypass ? prod[HILO_W-1:0]      : lo_q;
        rd_data = '0;
        if (hi_rd)      rd_data = hi_src;
        else if (lo_rd) rd_data = lo_src;
    end

endmodule
`default_nettype wire

// File: rtl/mul_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_hilo_ctrl
// Purpose  : Sequences a multicycle 32x32 external multiplier: latches the
//            operands, holds them for LATENCY edges, then captures the 64-bit
//            product into HI/LO. Arbitrates mfhi/mflo/mthi/mtlo against an
//            in-flight multiply by raising stall.
// Params   : LATENCY (1..15) - edges the operands are held before WRITE
// Macro    : HILO_BYPASS_EN  - reads in WRITE forward mul_p instead of stalling
// Ports    : clk, clr_n; start/ready; op_a/op_b -> mul_m/mul_q; mul_p in;
//            done; hi_rd/lo_rd/rd_data; hi_wr/lo_wr/wr_data; stall; hi_q/lo_q
// Revision : 1.0 - initial release
// ============================================================================
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    output logic              ready,
    input  logic [HILO_W-1:0] op_a,
    input  logic [HILO_W-1:0] op_b,
    output logic [HILO_W-1:0] mul_m,
    output logic [HILO_W-1:0] mul_q,
    input  logic [PROD_W-1:0] mul_p,
    output logic              done,
    input  logic              hi_rd,
    input  logic              lo_rd,
    output logic [HILO_W-1:0] rd_data,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [HILO_W-1:0] wr_data,
    output logic              stall,
    output logic [HILO_W-1:0] hi_q,
    output logic [HILO_W-1:0] lo_q
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;
    logic             rd_bypass;
    logic             any_rd;
    logic             any_wr;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CALC;
            ST_CALC:  if (cnt == '0) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        ready   = (state == ST_IDLE);
        accept  = ready & start;
        capture = (state == ST_WRITE);
        any_rd  = hi_rd | lo_rd;
        any_wr  = hi_wr | lo_wr;
`ifdef HILO_BYPASS_EN
        // The product is already settled in WRITE, so reads can be served
        // straight from mul_p; writes must still wait for the capture.
        rd_bypass = capture;
        stall     = (any_wr & ~ready) | (any_rd & ~ready & ~capture);
`else
        rd_bypass = 1'b0;
        stall     = (any_rd | any_wr) & ~ready;
`endif
    end

    // ---------------- operand / counter / done registers ----------------
    // Operands are only reloaded on an accepted start, so the multiplier
    // inputs stay stable through CALC and until the next request.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt   <= '0;
            mul_m <= '0;
            mul_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= capture;
            if (accept) begin
                mul_m <= op_a;
                mul_q <= op_b;
                cnt   <= CNT_LOAD;
            end else if ((state == ST_CALC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Writes are only honoured in IDLE; a write coinciding with an accepted
    // start lands now and is later overwritten by the product capture.
    hilo_regfile u_hilo (
        .clk       (clk),
        .clr_n     (clr_n),
        .capture   (capture),
        .prod      (mul_p),
        .hi_we     (hi_wr & ready),
        .lo_we     (lo_wr & ready),
        .wr_data   (wr_data),
        .hi_rd     (hi_rd),
        .lo_rd     (lo_rd),
        .rd_bypass (rd_bypass),
        .hi_q      (hi_q),
        .lo_q      (lo_q),
        .rd_data   (rd_data)
    );

endmodule
`default_nettype wire

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencing and result-capture stage that sits directly in front of and behind the datapath's combinational 32x32 signed Booth multiplier (ports m, q in; 64-bit p out). It accepts a multiply request from the control unit, holds the operands stable on the multiplier inputs for a fixed multicycle settling window, and captures the 64-bit product into the architectural HI/LO registers. It also arbitrates mfhi/mflo/mthi/mtlo accesses against an in-flight multiply.

## Interface
Parameters:
- LATENCY, 4, number of clock edges the multiplier inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  multiply request; accepted only when ready=1.
- ready  out  1  high while in IDLE.
- op_a, op_b  in  32  signed multiplicand and multiplier, sampled on the accepting edge.
- mul_m, mul_q  out  32  registered operands driven to the multiplier's m and q inputs.
- mul_p  in  64  product from the multiplier.
- done  out  1  one-cycle pulse; HI/LO hold the new product.
- hi_rd, lo_rd  in  1  mfhi/mflo read requests.
- rd_data  out  32  selected HI or LO value (combinational).
- hi_wr, lo_wr  in  1  mthi/mtlo write strobes.
- wr_data  in  32  write data for mthi/mtlo.
- stall  out  1  access must be held; request not serviced this cycle.
- hi_q, lo_q  out  32  current HI and LO register contents.

## Operation
- States: IDLE, CALC, WRITE; 4-bit down-counter cnt.
- IDLE: if start: mul_m<=op_a, mul_q<=op_b, cnt<=LATENCY-1, go CALC.
- CALC: if cnt==0 go WRITE, else cnt<=cnt-1.
- WRITE: HI<=mul_p[63:32], LO<=mul_p[31:0], done<=1, go IDLE.
- mul_m and mul_q are held constant from acceptance until the next accepted start.
- start while not IDLE is ignored; it is neither queued nor counted.
- rd_data: HI if hi_rd, else LO if lo_rd, else 0. hi_rd has priority when both are set.
- hi_wr/lo_wr in IDLE: register updated at the edge. Writes in the same cycle as an accepted start are performed, then overwritten by the product at WRITE.
- stall = (hi_rd|lo_rd|hi_wr|lo_wr) & (state!=IDLE). A stalled write is dropped by this block; the requester must hold it.
- Sign handling is entirely in the multiplier. This block does no arithmetic beyond bit slicing.

## Timing
- Reset (clr_n low, any state, including mid-CALC): state=IDLE, cnt=0, HI=LO=0, mul_m=mul_q=0, done=0. ready=1 once reset releases; any in-flight multiply is discarded.
- Accepting edge E0 → CALC. Edge E(LATENCY) → WRITE. Edge E(LATENCY+1) writes HI/LO and raises done; the state is IDLE in that same cycle.
- done is high for exactly the one cycle after E(LATENCY+1). ready is high in that same cycle, so a back-to-back start is accepted at E(LATENCY+2).
- start held continuously high: a new multiply begins every LATENCY+2 edges.
- LATENCY=1: E0→CALC, E1→WRITE, E2 captures.

## Configuration
- HILO_BYPASS_EN defined:
  - In WRITE, reads do not stall.
  - rd_data returns mul_p[63:32] for hi_rd or mul_p[31:0] for lo_rd.
  - Writes still stall in WRITE.
- HILO_BYPASS_EN undefined: all accesses stall in WRITE, as in CALC.

## Structure
- Shared package holds:
  - state enum ST_IDLE=2'd0, ST_CALC=2'd1, ST_WRITE=2'd2;
  - HILO_W=32 and PROD_W=64.
- Sub-module hilo_regfile: HI/LO registers with async clear, priority product capture over mthi/mtlo, and the rd_data mux.
- The multiplier is instantiated in the bench and the datapath alongside this block, not inside it.

## Test plan
- Reset: drive clr_n low mid-simulation → hi_q=lo_q=0, ready=1, done=0, mul_m=mul_q=0.
- op_a=7, op_b=-3, LATENCY=4 → done in the cycle after E5; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- op_a=op_b=0x80000000 → HI=0x40000000, LO=0x00000000. Then a second start at E(LATENCY+2) is accepted with no gap.
- hi_rd during CALC → stall=1 every cycle until IDLE, then rd_data equals the new HI. start pulsed during CALC is ignored; mul_m is unchanged.
- HILO_BYPASS_EN, lo_rd asserted in WRITE → stall=0 and rd_data=mul_p[31:0]. Same stimulus without the macro → stall=1.
- clr_n pulsed low during CALC with HI=0x12345678 beforehand → HI=0, no done pulse; the next start completes normally.
